// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types, register bit positions and command helpers
//               for the HD44780-style LCD write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Sequencer states for one RS/DATA/EN bus cycle plus its execution wait
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4
    } lcd_state_e;

    // Bit positions inside the memory-mapped LCD register
    localparam int LCD_ON_BIT   = 31;
    localparam int LCD_BLON_BIT = 30;
    localparam int LCD_RS_BIT   = 9;
    localparam int LCD_RW_BIT   = 8;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_write_ctrl
// Description : Converts CPU stores to the LCD register into timed
//               RS/DATA/EN write cycles followed by the controller execution
//               wait. One write can be queued while a cycle is in flight;
//               overwriting a queued write sets a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_write_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP_CYC      = 3,
    parameter int T_EN_CYC         = 12,
    parameter int T_HOLD_CYC       = 2,
    parameter int T_WAIT_SHORT_CYC = 2000,
    parameter int T_WAIT_LONG_CYC  = 82000,
    parameter int CNT_W            = 17
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    input  logic        i_lcd_wr,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun
);

    // Largest delay any phase can request; the counter must hold value-1
    localparam int c_max_cyc =
        (T_WAIT_LONG_CYC > T_WAIT_SHORT_CYC) ?
            ((T_WAIT_LONG_CYC > T_EN_CYC) ? T_WAIT_LONG_CYC : T_EN_CYC) :
            ((T_WAIT_SHORT_CYC > T_EN_CYC) ? T_WAIT_SHORT_CYC : T_EN_CYC);

    // Counter reload values: a phase of T cycles counts T-1 down to 0
    localparam logic [CNT_W-1:0] c_setup_ld = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_en_ld    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] c_hold_ld  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_short_ld = CNT_W'(T_WAIT_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] c_long_ld  = CNT_W'(T_WAIT_LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // Reject parameter sets the counter cannot represent or zero-length phases
    generate
        if (((c_max_cyc - 1) >> CNT_W) != 0) begin : g_cnt_w_too_small
            $error("lcd_write_ctrl: CNT_W=%0d cannot hold %0d", CNT_W, c_max_cyc - 1);
        end
        if (T_SETUP_CYC < 1 || T_EN_CYC < 1 || T_HOLD_CYC < 1 ||
            T_WAIT_SHORT_CYC < 1 || T_WAIT_LONG_CYC < 1) begin : g_zero_phase
            $error("lcd_write_ctrl: every phase must last at least one cycle");
        end
    endgenerate

    lcd_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_en;
    logic             r_on;
    logic             r_blon;
    logic             r_done;
    logic             r_overrun;
    logic             r_pend_valid;
    logic [7:0]       r_pend_data;
    logic             r_pend_rs;

    logic [7:0]       w_wr_data;
    logic             w_wr_rs;
    logic             w_cnt_zero;
    logic             w_wait_last;
    logic             w_unused;

    assign w_wr_data   = i_lcd_reg[7:0];
    assign w_wr_rs     = i_lcd_reg[LCD_RS_BIT];
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_wait_last = (r_state == WAIT) && w_cnt_zero;

    // RW and the reserved bits carry nothing for a write-only sequencer
    assign w_unused = &{1'b0, i_lcd_reg[29:10], i_lcd_reg[LCD_RW_BIT]};

    // Sequencer: phase timing, bus registers, pending buffer and status flags
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_data       <= 8'h00;
            r_rs         <= 1'b0;
            r_en         <= 1'b0;
            r_on         <= 1'b0;
            r_blon       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= 8'h00;
            r_pend_rs    <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Power and backlight follow every store, whatever the sequencer is doing
            if (i_lcd_wr) begin
                r_on   <= i_lcd_reg[LCD_ON_BIT];
                r_blon <= i_lcd_reg[LCD_BLON_BIT];
            end

            // A store arriving mid-transaction is queued unless WAIT consumes it now
            if (i_lcd_wr && (r_state != IDLE) && !w_wait_last) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= w_wr_data;
                r_pend_rs    <= w_wr_rs;
                if (r_pend_valid) begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (i_lcd_wr) begin
                        r_data  <= w_wr_data;
                        r_rs    <= w_wr_rs;
                        r_cnt   <= c_setup_ld;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_cnt_zero) begin
                        r_en    <= 1'b1;
                        r_cnt   <= c_en_ld;
                        r_state <= PULSE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                PULSE: begin
                    if (w_cnt_zero) begin
                        r_en    <= 1'b0;
                        r_cnt   <= c_hold_ld;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                HOLD: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= is_long_cmd(r_rs, r_data) ? c_long_ld : c_short_ld;
                        r_state <= WAIT;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                WAIT: begin
                    if (w_cnt_zero) begin
                        r_done <= 1'b1;
                        if (i_lcd_wr) begin
                            // A same-cycle store wins over the queued one
                            r_data       <= w_wr_data;
                            r_rs         <= w_wr_rs;
                            r_cnt        <= c_setup_ld;
                            r_state      <= SETUP;
                            r_pend_valid <= 1'b0;
                            if (r_pend_valid) begin
                                r_overrun <= 1'b1;
                            end
                        end else if (r_pend_valid) begin
                            r_data       <= r_pend_data;
                            r_rs         <= r_pend_rs;
                            r_cnt        <= c_setup_ld;
                            r_state      <= SETUP;
                            r_pend_valid <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_lcd_data = r_data;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_en;
    assign o_lcd_on   = r_on;
    assign o_lcd_blon = r_blon;
    assign o_busy     = (r_state != IDLE) || r_pend_valid;
    assign o_done     = r_done;
    assign o_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_write_ctrl
// Description : Directed bench for lcd_write_ctrl with shortened timings.
//               Expected bus writes are queued as stores are issued and are
//               popped on every EN rising edge; phase timing is checked
//               against cycle numbers derived from the timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_write_ctrl;

    localparam int P_SETUP = 2;
    localparam int P_EN    = 3;
    localparam int P_HOLD  = 1;
    localparam int P_SHORT = 5;
    localparam int P_LONG  = 20;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_lcd_reg;
    logic        i_lcd_wr;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic        o_lcd_blon;
    logic        o_busy;
    logic        o_done;
    logic        o_overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] sb[$];  // {rs, data} in expected issue order

    lcd_write_ctrl #(
        .T_SETUP_CYC      (P_SETUP),
        .T_EN_CYC         (P_EN),
        .T_HOLD_CYC       (P_HOLD),
        .T_WAIT_SHORT_CYC (P_SHORT),
        .T_WAIT_LONG_CYC  (P_LONG),
        .CNT_W            (17)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_lcd_reg  (i_lcd_reg),
        .i_lcd_wr   (i_lcd_wr),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_blon (o_lcd_blon),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_overrun  (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Edge counter used as the time base for timing expectations
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one store for one cycle; called at a negedge, returns at the next
    task automatic strobe(input logic [31:0] v, input bit issued);
        i_lcd_reg = v;
        i_lcd_wr  = 1'b1;
        if (issued) sb.push_back({v[9], v[7:0]});
        @(negedge i_clk);
        i_lcd_wr  = 1'b0;
    endtask

    // Sample from the current negedge until busy drops (inclusive) or limit expires
    task automatic watch(input int limit, output int busy_n, output int en_n,
                         output int en_first, output int done_n, output int done_last);
        busy_n = 0; en_n = 0; en_first = -1; done_n = 0; done_last = -1;
        for (int i = 0; i < limit; i++) begin
            if (i > 0) @(negedge i_clk);
            if (o_busy) busy_n++;
            if (o_lcd_en) begin
                en_n++;
                if (en_first < 0) en_first = cyc;
            end
            if (o_done) begin
                done_n++;
                done_last = cyc;
            end
            if (!o_busy) return;
        end
        chk("watch_timeout", 32'd1, 32'd0);
    endtask

    // Scoreboard monitor: pop on EN rise, check EN width on EN fall
    logic en_prev = 1'b0;
    int   en_run  = 0;
    always @(negedge i_clk) begin
        if (i_reset) begin
            en_prev = 1'b0;
            en_run  = 0;
        end else begin
            if (o_lcd_en && !en_prev) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_write", {23'd0, o_lcd_rs, o_lcd_data}, 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("sb_rs_data", {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, e});
                end
            end
            if (o_lcd_en) en_run++;
            if (!o_lcd_en && en_prev) begin
                chk("en_width", en_run, P_EN);
                en_run = 0;
            end
            en_prev = o_lcd_en;
        end
    end

    int t0;
    int busy_n, en_n, en_first, done_n, done_last;
    int nb, ne, nd;

    initial begin
        i_reset   = 1'b1;
        i_lcd_reg = 32'h0;
        i_lcd_wr  = 1'b0;
        repeat (3) @(negedge i_clk);

        // Reset state
        chk("rst_outputs", {23'd0, o_lcd_data, o_lcd_rs},  32'd0);
        chk("rst_flags", {25'd0, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_blon, o_busy, o_done, o_overrun}, 32'd0);
        #2 i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        // Data write 'A': latched at N+1, EN N+3..N+5, busy 11, done at N+12
        t0 = cyc;
        strobe(32'h0000_0241, 1'b1);
        chk("a_rs_data_n1", {23'd0, o_lcd_rs, o_lcd_data}, 32'h141);
        chk("a_busy_n1", o_busy, 1);
        watch(100, busy_n, en_n, en_first, done_n, done_last);
        chk("a_en_first", en_first, t0 + 1 + P_SETUP);
        chk("a_en_cnt", en_n, P_EN);
        chk("a_busy_cnt", busy_n, P_SETUP + P_EN + P_HOLD + P_SHORT);
        chk("a_done_cyc", done_last, t0 + 1 + P_SETUP + P_EN + P_HOLD + P_SHORT);
        chk("a_done_cnt", done_n, 1);
        chk("a_rw", o_lcd_rw, 0);
        repeat (2) @(negedge i_clk);

        // Clear display: long wait
        t0 = cyc;
        strobe(32'h0000_0001, 1'b1);
        chk("clr_rs_data", {23'd0, o_lcd_rs, o_lcd_data}, 32'h001);
        watch(200, busy_n, en_n, en_first, done_n, done_last);
        chk("clr_busy_cnt", busy_n, P_SETUP + P_EN + P_HOLD + P_LONG);
        chk("clr_done_cyc", done_last, t0 + 1 + P_SETUP + P_EN + P_HOLD + P_LONG);
        repeat (2) @(negedge i_clk);

        // Two stores back-to-back: second issues straight out of WAIT
        t0 = cyc;
        strobe(32'h0000_0241, 1'b1);
        strobe(32'h0000_0242, 1'b1);
        watch(200, busy_n, en_n, en_first, done_n, done_last);
        chk("b2b_busy_cnt", busy_n, 2 * (P_SETUP + P_EN + P_HOLD + P_SHORT) - 1);
        chk("b2b_done_cnt", done_n, 2);
        chk("b2b_done_cyc", done_last, t0 + 1 + 2 * (P_SETUP + P_EN + P_HOLD + P_SHORT));
        chk("b2b_en_cnt", en_n, 2 * P_EN);
        chk("b2b_overrun", o_overrun, 0);
        repeat (2) @(negedge i_clk);

        // Three stores: middle one overwritten, overrun sticky
        t0 = cyc;
        strobe(32'h0000_0241, 1'b1);
        strobe(32'h0000_0242, 1'b0);
        strobe(32'h0000_0243, 1'b1);
        chk("ovr_flag_set", o_overrun, 1);
        watch(200, busy_n, en_n, en_first, done_n, done_last);
        chk("ovr_busy_cnt", busy_n, 2 * (P_SETUP + P_EN + P_HOLD + P_SHORT) - 2);
        chk("ovr_done_cnt", done_n, 2);
        chk("ovr_flag_held", o_overrun, 1);
        repeat (2) @(negedge i_clk);

        // Power/backlight store in the middle of an EN pulse
        t0 = cyc;
        strobe(32'h0000_0241, 1'b1);
        repeat (2) @(negedge i_clk);
        chk("pwr_en_before", o_lcd_en, 1);
        chk("pwr_on_before", {30'd0, o_lcd_on, o_lcd_blon}, 32'd0);
        strobe(32'hC000_0000, 1'b1);
        chk("pwr_on_after", {30'd0, o_lcd_on, o_lcd_blon}, 32'd3);
        chk("pwr_en_after", o_lcd_en, 1);
        watch(300, busy_n, en_n, en_first, done_n, done_last);
        chk("pwr_busy_cnt", busy_n,
            (P_SETUP + P_EN + P_HOLD + P_SHORT) - 3 + (P_SETUP + P_EN + P_HOLD + P_LONG));
        chk("pwr_en_cnt", en_n, 2 * P_EN - 1);
        chk("pwr_done_cyc", done_last,
            t0 + 1 + 2 * (P_SETUP + P_EN + P_HOLD) + P_SHORT + P_LONG);
        chk("pwr_overrun_sticky", o_overrun, 1);
        repeat (2) @(negedge i_clk);

        // Reset in the middle of an EN pulse
        strobe(32'h0000_0241, 1'b1);
        repeat (3) @(negedge i_clk);
        chk("rstp_en_before", o_lcd_en, 1);
        #2 i_reset = 1'b1;
        #1;
        chk("rstp_en_now", o_lcd_en, 0);
        chk("rstp_outputs", {23'd0, o_lcd_data, o_lcd_rs}, 32'd0);
        chk("rstp_flags", {25'd0, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_blon, o_busy, o_done, o_overrun}, 32'd0);
        repeat (2) @(negedge i_clk);
        #2 i_reset = 1'b0;
        nb = 0; ne = 0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_busy) nb++;
            if (o_lcd_en) ne++;
            if (o_done) nd++;
        end
        chk("rstp_idle_busy", nb, 0);
        chk("rstp_idle_en", ne, 0);
        chk("rstp_no_done", nd, 0);

        // Normal operation resumes after reset
        strobe(32'h0000_0248, 1'b1);
        watch(100, busy_n, en_n, en_first, done_n, done_last);
        chk("post_busy_cnt", busy_n, P_SETUP + P_EN + P_HOLD + P_SHORT);
        chk("post_done_cnt", done_n, 1);
        repeat (2) @(negedge i_clk);

        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
